// File: rtl/app_ctrl_pkg.sv
// Shared encodings for the application mode sequencer: output mux select values,
// menu cursor indices and loading-bar geometry.
package app_ctrl_pkg;

  // Output mux select; values 7..15 are never produced and recover to ST_MENU.
  typedef enum logic [3:0] {
    ST_MENU         = 4'd0,
    ST_VOLUME       = 4'd1,
    ST_POKEMON      = 4'd2,
    ST_POKEMON_OVER = 4'd3,
    ST_BLANK        = 4'd4,
    ST_POTION       = 4'd5,
    ST_LOADING      = 4'd6
  } app_state_e;

  localparam logic [1:0] CUR_VOLUME  = 2'd0;
  localparam logic [1:0] CUR_POKEMON = 2'd1;
  localparam logic [1:0] CUR_POTION  = 2'd2;

  localparam int unsigned BAR_PIXELS = 96;

  // App state entered once loading for a given menu item completes.
  function automatic app_state_e target_state(input logic [1:0] target);
    case (target)
      CUR_VOLUME:  return ST_VOLUME;
      CUR_POKEMON: return ST_POKEMON;
      CUR_POTION:  return ST_POTION;
      default:     return ST_MENU;
    endcase
  endfunction

  // One-hot start pulse pattern for a given menu item.
  function automatic logic [2:0] target_onehot(input logic [1:0] target);
    case (target)
      CUR_VOLUME:  return 3'b001;
      CUR_POKEMON: return 3'b010;
      CUR_POTION:  return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/app_state_controller_loading_timer.sv
// Loading-bar timer: a LOAD_STEP prescaler advancing a 7-bit pixel counter.
// done_o is combinational and fires on the edge that completes the last pixel.
module loading_timer
  import app_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STEP = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       enable_i,
  output logic [6:0] progress_o,
  output logic       done_o
);

  localparam int unsigned PW = (LOAD_STEP > 1) ? $clog2(LOAD_STEP) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(LOAD_STEP - 1);
  localparam logic [6:0] PROG_MAX = 7'(BAR_PIXELS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    prog_q, prog_d;
  logic          wrap;

  assign wrap       = enable_i && (presc_q == PRESC_MAX);
  assign done_o     = wrap && (prog_q == PROG_MAX);
  assign progress_o = prog_q;

  // Next-state: held at zero while idle, bar advances once per prescaler wrap.
  always_comb begin
    presc_d = presc_q;
    prog_d  = prog_q;
    if (start_i || !enable_i) begin
      presc_d = '0;
      prog_d  = '0;
    end else if (wrap) begin
      presc_d = '0;
      prog_d  = done_o ? 7'd0 : prog_q + 7'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      prog_q  <= '0;
    end else begin
      presc_q <= presc_d;
      prog_q  <= prog_d;
    end
  end

endmodule

// File: rtl/app_state_controller.sv
// Top-level mode sequencer driving the OLED/7-seg output mux select.
// Optional screensaver (menu idle -> BLANK) enabled by defining APP_SCREENSAVER_EN.
module app_state_controller
  import app_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STEP   = 1_000_000,
  parameter logic [31:0] IDLE_CYCLES = 32'd3_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       game_over,
  output logic [3:0] state,
  output logic [1:0] menu_cursor,
  output logic [6:0] load_progress,
  output logic [2:0] app_start
);

  app_state_e state_q, state_d;
  logic [1:0] cursor_q, cursor_d;
  logic [1:0] target_q, target_d;
  logic [2:0] app_start_q, app_start_d;
  logic       load_start;
  logic       load_done;

`ifdef APP_SCREENSAVER_EN
  logic [31:0] idle_q, idle_d;
  logic        any_btn;
  assign any_btn = btn_c | btn_u | btn_d | btn_l;
`else
  logic unused_idle_cycles;
  assign unused_idle_cycles = ^IDLE_CYCLES;
`endif

  loading_timer #(
    .LOAD_STEP (LOAD_STEP)
  ) u_loading_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (load_start),
    .enable_i   (state_q == ST_LOADING),
    .progress_o (load_progress),
    .done_o     (load_done)
  );

  // Mode transitions, cursor movement and start-pulse generation.
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    target_d    = target_q;
    app_start_d = 3'b000;
    load_start  = 1'b0;
`ifdef APP_SCREENSAVER_EN
    idle_d      = '0;
`endif
    case (state_q)
      ST_MENU: begin
        // Select takes the pre-move cursor; a coincident move is dropped.
        if (btn_c) begin
          target_d   = cursor_q;
          state_d    = ST_LOADING;
          load_start = 1'b1;
        end else if (btn_u && !btn_d) begin
          cursor_d = (cursor_q == CUR_VOLUME || cursor_q > CUR_POTION) ? CUR_POTION
                                                                       : cursor_q - 2'd1;
        end else if (btn_d && !btn_u) begin
          cursor_d = (cursor_q >= CUR_POTION) ? CUR_VOLUME : cursor_q + 2'd1;
        end
`ifdef APP_SCREENSAVER_EN
        if (!any_btn) begin
          if (idle_q == IDLE_CYCLES - 32'd1) begin
            state_d = ST_BLANK;
          end else begin
            idle_d = idle_q + 32'd1;
          end
        end
`endif
      end
      ST_LOADING: begin
        if (load_done) begin
          state_d     = target_state(target_q);
          app_start_d = target_onehot(target_q);
        end
      end
      ST_VOLUME, ST_POTION: begin
        if (btn_l) state_d = ST_MENU;
      end
      ST_POKEMON: begin
        if (game_over) begin
          state_d = ST_POKEMON_OVER;
        end else if (btn_l) begin
          state_d = ST_MENU;
        end
      end
      ST_POKEMON_OVER: begin
        if (btn_l) begin
          state_d = ST_MENU;
        end else if (btn_c) begin
          target_d   = CUR_POKEMON;
          state_d    = ST_LOADING;
          load_start = 1'b1;
        end
      end
      ST_BLANK: begin
`ifdef APP_SCREENSAVER_EN
        // Waking pulse is consumed: no cursor move or select.
        if (any_btn) state_d = ST_MENU;
`else
        state_d = ST_MENU;
`endif
      end
      default: state_d = ST_MENU;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_MENU;
      cursor_q    <= CUR_VOLUME;
      target_q    <= CUR_VOLUME;
      app_start_q <= 3'b000;
`ifdef APP_SCREENSAVER_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      target_q    <= target_d;
      app_start_q <= app_start_d;
`ifdef APP_SCREENSAVER_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign state       = state_q;
  assign menu_cursor = cursor_q;
  assign app_start   = app_start_q;

endmodule

// File: tb/tb_app_state_controller.sv
// Self-checking bench for app_state_controller with a cycle-level behavioural model.
// Honours APP_SCREENSAVER_EN the same way as the design.
module tb_app_state_controller;

  localparam int LS   = 4;
  localparam int IDLE = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, game_over = 1'b0;
  logic [3:0] state;
  logic [1:0] menu_cursor;
  logic [6:0] load_progress;
  logic [2:0] app_start;

  app_state_controller #(
    .LOAD_STEP   (LS),
    .IDLE_CYCLES (32'd50)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_c         (btn_c),
    .btn_u         (btn_u),
    .btn_d         (btn_d),
    .btn_l         (btn_l),
    .game_over     (game_over),
    .state         (state),
    .menu_cursor   (menu_cursor),
    .load_progress (load_progress),
    .app_start     (app_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode number, cursor, chosen item, cycles spent loading, idle run length.
  int m_state, m_cursor, m_target, m_elapsed, m_start, m_idle;
  int app_map[3] = '{1, 2, 5};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_progress();
    return (m_state == 6) ? m_elapsed / LS : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cursor = 0; m_target = 0; m_elapsed = 0; m_start = 0; m_idle = 0;
  endtask

  task automatic model_update(input bit c, input bit u, input bit d, input bit l, input bit g);
    m_start = 0;
    case (m_state)
      0: begin
        if (c) begin
          m_target = m_cursor; m_state = 6; m_elapsed = 0;
        end else if (u && !d) m_cursor = (m_cursor + 2) % 3;
        else if (d && !u) m_cursor = (m_cursor + 1) % 3;
`ifdef APP_SCREENSAVER_EN
        if (m_state == 0) begin
          if (c | u | d | l) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == IDLE) m_state = 4;
          end
        end
`endif
      end
      6: begin
        m_elapsed++;
        if (m_elapsed == 96 * LS) begin
          m_state = app_map[m_target];
          m_start = 1 << m_target;
        end
      end
      1, 5: if (l) m_state = 0;
      2: begin
        if (g) m_state = 3;
        else if (l) m_state = 0;
      end
      3: begin
        if (l) m_state = 0;
        else if (c) begin
          m_target = 1; m_state = 6; m_elapsed = 0;
        end
      end
      4: if (c | u | d | l) m_state = 0;
      default: m_state = 0;
    endcase
    if (m_state != 0) m_idle = 0;
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("cursor", int'(menu_cursor), m_cursor);
    check("progress", int'(load_progress), exp_progress());
    check("app_start", int'(app_start), m_start);
  endtask

  task automatic step(input bit c, input bit u, input bit d, input bit l, input bit g);
    btn_c = c; btn_u = u; btn_d = d; btn_l = l; game_over = g;
    @(posedge clk);
    model_update(c, u, d, l, g);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; game_over = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  // Idles until the DUT reaches want (bounded) and checks the loading length.
  task automatic run_load(input int want);
    int n = 0;
    while (int'(state) != want && n < 500) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    check("load_len", n, 96 * LS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g_lvl;
    #1;
    apply_reset();

    // Cursor wrap and cancelling moves.
    step(0, 0, 1, 0, 0); check("d1", int'(menu_cursor), 1);
    step(0, 0, 1, 0, 0); check("d2", int'(menu_cursor), 2);
    step(0, 0, 1, 0, 0); check("d3", int'(menu_cursor), 0);
    step(0, 1, 0, 0, 0); check("u_wrap", int'(menu_cursor), 2);
    step(0, 1, 1, 0, 0); check("ud_hold", int'(menu_cursor), 2);

    // Pokemon load, game over, restart, exit.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0); check("to_load", int'(state), 6);
    run_load(2);
    step(0, 0, 0, 1, 1); check("go_wins", int'(state), 3);
    step(1, 0, 0, 0, 1); check("restart", int'(state), 6);
    run_load(2);
    step(0, 0, 0, 0, 1); check("over2", int'(state), 3);
    step(1, 0, 0, 1, 0); check("l_wins", int'(state), 0);
    check("cursor_kept", int'(menu_cursor), 1);

    // Reset during potion load at progress 40.
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 400 && exp_progress() != 40; k++) step(0, 0, 0, 0, 0);
    check("prog40", int'(load_progress), 40);
    apply_reset();
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);

    // Menu idle behaviour.
    step(0, 0, 1, 0, 0);
`ifdef APP_SCREENSAVER_EN
    for (int k = 0; k < IDLE - 1; k++) step(0, 0, 0, 0, 0);
    check("idle49", int'(state), 0);
    step(0, 0, 0, 0, 0);
    check("blank", int'(state), 4);
    step(0, 0, 1, 0, 0);
    check("wake", int'(state), 0);
    check("wake_cursor", int'(menu_cursor), 1);
`else
    for (int k = 0; k < 200; k++) step(0, 0, 0, 0, 0);
    check("no_blank", int'(state), 0);
`endif

    // Select coincident with a move: pre-move cursor wins.
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    check("sel_cursor", int'(menu_cursor), 0);
    run_load(1);
    step(0, 0, 0, 1, 0); check("vol_exit", int'(state), 0);

    // Random traffic against the model.
    g_lvl = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) g_lvl = ~g_lvl;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, g_lvl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/app_state_controller.md
Name: app_state_controller

Overview:
- Top-level mode sequencer that generates the 4-bit `state` select consumed by the final OLED/7-segment output mux.
- Runs the main menu: cursor movement, app selection, a timed loading screen before each app, and return paths from apps and game-over.
- Emits one-cycle start pulses so each app can re-initialise on entry.

Parameters:
- LOAD_STEP, 1_000_000, clk cycles per loading-bar pixel; full load = 96*LOAD_STEP cycles.
- IDLE_CYCLES, 3_000_000_000, menu inactivity cycles before the screensaver (used only with the macro); 32-bit.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_c  input  1  centre button, one-cycle debounced pulse (select/confirm)
- btn_u  input  1  up pulse (cursor up)
- btn_d  input  1  down pulse (cursor down)
- btn_l  input  1  left pulse (exit app to menu)
- game_over  input  1  level from the pokemon game, high when the player has lost
- state  output  4  mux select: 0 MENU, 1 VOLUME, 2 POKEMON, 3 POKEMON_OVER, 4 BLANK, 5 POTION, 6 LOADING
- menu_cursor  output  2  highlighted item: 0 volume, 1 pokemon, 2 potion
- load_progress  output  7  loading bar length in pixels, 0..95
- app_start  output  3  one-hot one-cycle pulse on app entry: bit0 volume, bit1 pokemon, bit2 potion

Behaviour:
- Clocking and reset: all outputs registered. While rst_n=0, asynchronously force state=MENU, menu_cursor=0, load_progress=0, app_start=0, and clear the latched target and all counters.
- Latency: every output responds on the first clk edge after the qualifying input cycle.
- MENU:
  - btn_u decrements menu_cursor, wrapping 0→2.
  - btn_d increments menu_cursor, wrapping 2→0.
  - btn_u and btn_d in the same cycle: no move.
  - btn_c latches target = menu_cursor (pre-move value if a move pulse coincides; that move is discarded), then goes to LOADING with load_progress=0.
- LOADING:
  - A prescaler counts 0..LOAD_STEP-1. On each wrap, load_progress increments.
  - The wrap with load_progress=95 goes to the target state, sets load_progress=0 and pulses app_start[target] for exactly one cycle.
  - All buttons are ignored. Loading time is exactly 96*LOAD_STEP cycles from the btn_c edge.
- VOLUME / POTION: btn_l → MENU; menu_cursor is kept.
- POKEMON:
  - game_over=1 → POKEMON_OVER.
  - btn_l → MENU.
  - Both in the same cycle: game_over wins.
- POKEMON_OVER:
  - btn_c → LOADING with target=pokemon (restart).
  - btn_l → MENU.
  - Both in the same cycle: btn_l wins.
- Invalid state values (7..15) recover to MENU on the next edge.
- Reset asserted mid-LOADING: load abandoned, no app_start pulse issued.

Optional Feature:
- Macro: APP_SCREENSAVER_EN.
- Defined:
  - A 32-bit idle counter runs in MENU and clears on any button pulse or on leaving MENU.
  - When it reaches IDLE_CYCLES-1, state→BLANK.
  - In BLANK, any button pulse → MENU. That pulse is consumed: no cursor move, no select. Cursor is preserved.
- Undefined: no idle counter, and BLANK (4) is never produced.

Decomposition:
- Package app_ctrl_pkg holds:
  - state encodings ST_MENU..ST_LOADING (4-bit)
  - cursor indices CUR_VOLUME/CUR_POKEMON/CUR_POTION
  - BAR_PIXELS=96
- Sub-module loading_timer:
  - LOAD_STEP prescaler plus 7-bit progress counter.
  - Inputs: start, enable. Outputs: progress, done pulse.

Test Plan:
- Bench uses LOAD_STEP=4, IDLE_CYCLES=50.
- Reset, then btn_d ×3 → menu_cursor 1,2,0. Then btn_u → 2. btn_u+btn_d together → stays 2.
- Cursor=1, btn_c → state=6. load_progress steps every 4 cycles to 95. State=2 exactly 384 cycles after the btn_c edge, with app_start=3'b010 for one cycle.
- In POKEMON, game_over=1 together with btn_l → state=3. Then btn_c → 6 → 2 after 384 cycles. Repeat and issue btn_l → 0.
- Cursor=2 select, then pulse rst_n low at load_progress=40 → state=0, cursor=0, progress=0, no app_start pulse.
- With APP_SCREENSAVER_EN: 50 idle cycles in MENU → state=4. btn_d → state=0 with cursor unchanged. Without the macro: 200 idle cycles → state stays 0.
- btn_c coincident with btn_d at cursor=0 → target volume (state 1 after loading), cursor stays 0.
